branch_commiter: RTL and testbench
==================================

Name: branch_commiter

Overview:
- Commit-side consumer of the branch/compare ALU (alu1) result interface.
- Captures each ALU1 result, writes SLT/SLTU results to the register file, updates the branch predictor, and redirects fetch with a pipeline flush on mispredict.
- Returns the `clear` handshake to the ALU and raises a precise exception on ALU errors.
- Sits between alu1 and the register file / fetch / predictor.

Parameters:
- XLEN, 32, datapath width (core_config_pkg::XLEN).
- REG_ADDR_W, 5, register index width (core_config_pkg::REG_ADDR_W).
- FLUSH_CYCLES, 3, cycles the unit stays in DRAIN after a redirect ack; range 1..15.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alu_res  in  XLEN  SLT result or branch target
- alu_rd  in  REG_ADDR_W  destination register
- alu_valid  in  1  result valid
- alu_o_error  in  1  target overflow
- alu_i_error  in  1  unknown command
- alu_req  in  1  branch taken / condition true
- alu_mispredict  in  1  prediction wrong
- alu_is_branch  in  1  issuer sideband: op is a branch
- alu_pc  in  XLEN  issuer sideband: branch PC
- clear  out  1  consume pulse to ALU
- rf_we  out  1  register write enable
- rf_waddr  out  REG_ADDR_W  write index
- rf_wdata  out  XLEN  write data
- bp_update  out  1  predictor update strobe
- bp_pc  out  XLEN  updated branch PC
- bp_taken  out  1  resolved direction
- flush  out  1  pipeline flush pulse
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  XLEN  redirect target
- redirect_ack  in  1  fetch accepted redirect
- exc_valid  out  1  exception request (sticky)
- exc_cause  out  2  0 none, 1 unknown instr, 2 target overflow
- exc_ack  in  1  trap unit accepted
- busy  out  1  state != IDLE
- branch_cnt  out  CNT_W  branches committed, saturating
- mispredict_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset is asynchronous, asserted at any state, including mid-REDIRECT or mid-FAULT.
- States: IDLE, COMMIT, REDIRECT, DRAIN, FAULT.
- IDLE, alu_valid=1: latch all alu_* inputs; assert `clear` for exactly 1 cycle (registered, in the next cycle); go to COMMIT.
- COMMIT, 1 cycle:
  - If i_error or o_error: set exc_valid=1; set exc_cause (i_error has priority, cause 1); no rf/bp writes; go to FAULT.
  - Else if !is_branch: rf_we=1 when rd!=0, rf_waddr=rd, rf_wdata=res; go to IDLE.
  - Else (branch):
    - Pulse bp_update with bp_pc=pc and bp_taken=req.
    - branch_cnt +1, saturating at all-ones.
    - If mispredict: flush=1 for 1 cycle; redirect_valid=1; redirect_pc = req ? res : pc+4 (mod 2^XLEN); mispredict_cnt +1, saturating; go to REDIRECT.
    - Otherwise go to IDLE.
- REDIRECT: hold redirect_valid and redirect_pc stable until redirect_ack. In the ack cycle, drop redirect_valid next cycle, load the drain counter with FLUSH_CYCLES, go to DRAIN.
- DRAIN: decrement the counter each cycle. Any alu_valid seen here is wrong-path: assert `clear` the following cycle, discard the result with no side effects, and leave counters unchanged. At 0, go to IDLE.
- FAULT: hold exc_valid and exc_cause until exc_ack. On ack, clear both and go to IDLE. alu_valid is ignored (not cleared) while in FAULT.
- Throughput: one result per 2 cycles in the non-mispredict case (IDLE→COMMIT→IDLE).
- alu_valid in COMMIT or REDIRECT: not sampled; the ALU holds its result because no `clear` has been issued.
- redirect_ack arriving in the same cycle redirect_valid first rises is legal; DRAIN starts the next cycle.

Decomposition:
- core_config_pkg gets:
  - commit_state_t, a 3-bit enum.
  - exc_cause_t with values EXC_NONE, EXC_ILLEGAL, EXC_TGT_OVF.
  - constant PC_STEP = 4.
- Sub-module sat_counter (parameter W; inputs inc, clr; output cnt) is instantiated twice for the performance counters.

Test Plan:
- SLT writeback: alu_valid with res=1, rd=5, is_branch=0 → clear high at t+1; rf_we=1, waddr=5, wdata=1 at t+2; state back to IDLE.
- Correctly predicted taken BEQ: pc=0x100, res=0x140, req=1, mispredict=0 → bp_update with bp_pc=0x100, bp_taken=1; no flush; branch_cnt=1, mispredict_cnt=0.
- Mispredict not-taken: pc=0x200, req=0, mispredict=1 → flush pulse; redirect_pc=0x204 held 4 cycles until ack; DRAIN 3 cycles; an alu_valid injected during DRAIN gets clear but no rf_we/bp_update.
- Mispredict wrap: pc=0xFFFFFFFC, req=0 → redirect_pc=0x00000000.
- Error priority: i_error=1 and o_error=1 → exc_cause=1; exc_valid held until exc_ack; no writes; alu_valid during FAULT produces no clear.
- Async reset asserted mid-REDIRECT → all outputs 0 immediately; IDLE after release; counters 0; saturation check: preload branch_cnt to all-ones, commit a branch → count stays all-ones.

Source files
------------

// File: rtl/core_config_pkg.sv
// Shared core configuration: datapath widths, commit FSM states, exception causes.
package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int PC_STEP    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COMMIT   = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FAULT    = 3'd4
    } commit_state_t;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_ILLEGAL = 2'd1,
        EXC_TGT_OVF = 2'd2
    } exc_cause_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count visible one cycle after inc.
// Backpressure: none; inc is a single-cycle strobe.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/branch_commiter.sv
// Commit-side consumer of alu1 results: RF writeback, predictor update, mispredict redirect, error traps.
// Latency: clear 1 cycle after capture, side effects 2 cycles after capture; one result per 2 cycles.
// Backpressure: ALU holds its result until clear; redirect/exception held until ack.
module branch_commiter #(
    parameter int XLEN         = core_config_pkg::XLEN,
    parameter int REG_ADDR_W   = core_config_pkg::REG_ADDR_W,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       alu_res,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic                  alu_valid,
    input  logic                  alu_o_error,
    input  logic                  alu_i_error,
    input  logic                  alu_req,
    input  logic                  alu_mispredict,
    input  logic                  alu_is_branch,
    input  logic [XLEN-1:0]       alu_pc,
    output logic                  clear,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  bp_update,
    output logic [XLEN-1:0]       bp_pc,
    output logic                  bp_taken,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    input  logic                  redirect_ack,
    output logic                  exc_valid,
    output logic [1:0]            exc_cause,
    input  logic                  exc_ack,
    output logic                  busy,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);
    import core_config_pkg::*;

    commit_state_t         state_q, state_d;
    logic [XLEN-1:0]       res_q, res_d, pc_q, pc_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  req_q, req_d, misp_q, misp_d, isbr_q, isbr_d;
    logic                  ierr_q, ierr_d, oerr_q, oerr_d;
    logic [3:0]            drain_q, drain_d;
    logic                  clear_q, clear_d, rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d, bp_pc_q, bp_pc_d;
    logic                  bp_update_q, bp_update_d, bp_taken_q, bp_taken_d, flush_q, flush_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
    logic                  exc_valid_q, exc_valid_d;
    exc_cause_t            exc_cause_q, exc_cause_d;
    logic                  br_inc, mp_inc;

    always_comb begin
        state_d          = state_q;
        res_d            = res_q;
        pc_d             = pc_q;
        rd_d             = rd_q;
        req_d            = req_q;
        misp_d           = misp_q;
        isbr_d           = isbr_q;
        ierr_d           = ierr_q;
        oerr_d           = oerr_q;
        drain_d          = drain_q;
        clear_d          = 1'b0;
        rf_we_d          = 1'b0;
        rf_waddr_d       = rf_waddr_q;
        rf_wdata_d       = rf_wdata_q;
        bp_update_d      = 1'b0;
        bp_pc_d          = bp_pc_q;
        bp_taken_d       = bp_taken_q;
        flush_d          = 1'b0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        exc_valid_d      = exc_valid_q;
        exc_cause_d      = exc_cause_q;
        br_inc           = 1'b0;
        mp_inc           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (alu_valid) begin
                    res_d   = alu_res;
                    pc_d    = alu_pc;
                    rd_d    = alu_rd;
                    req_d   = alu_req;
                    misp_d  = alu_mispredict;
                    isbr_d  = alu_is_branch;
                    ierr_d  = alu_i_error;
                    oerr_d  = alu_o_error;
                    clear_d = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (ierr_q || oerr_q) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = ierr_q ? EXC_ILLEGAL : EXC_TGT_OVF;
                    state_d     = ST_FAULT;
                end else if (!isbr_q) begin
                    rf_we_d    = (rd_q != '0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = res_q;
                    state_d    = ST_IDLE;
                end else begin
                    bp_update_d = 1'b1;
                    bp_pc_d     = pc_q;
                    bp_taken_d  = req_q;
                    br_inc      = 1'b1;
                    if (misp_q) begin
                        flush_d          = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = req_q ? res_q : (pc_q + XLEN'(PC_STEP));
                        mp_inc           = 1'b1;
                        state_d          = ST_REDIRECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REDIRECT: begin
                if (redirect_ack) begin
                    redirect_valid_d = 1'b0;
                    drain_d          = 4'(FLUSH_CYCLES);
                    state_d          = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wrong-path results are consumed but dropped; skip the cycle our own clear is still visible.
                if (alu_valid && !clear_q) begin
                    clear_d = 1'b1;
                end
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    drain_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (exc_ack) begin
                    exc_valid_d = 1'b0;
                    exc_cause_d = EXC_NONE;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            res_q            <= '0;
            pc_q             <= '0;
            rd_q             <= '0;
            req_q            <= 1'b0;
            misp_q           <= 1'b0;
            isbr_q           <= 1'b0;
            ierr_q           <= 1'b0;
            oerr_q           <= 1'b0;
            drain_q          <= '0;
            clear_q          <= 1'b0;
            rf_we_q          <= 1'b0;
            rf_waddr_q       <= '0;
            rf_wdata_q       <= '0;
            bp_update_q      <= 1'b0;
            bp_pc_q          <= '0;
            bp_taken_q       <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            exc_valid_q      <= 1'b0;
            exc_cause_q      <= EXC_NONE;
        end else begin
            state_q          <= state_d;
            res_q            <= res_d;
            pc_q             <= pc_d;
            rd_q             <= rd_d;
            req_q            <= req_d;
            misp_q           <= misp_d;
            isbr_q           <= isbr_d;
            ierr_q           <= ierr_d;
            oerr_q           <= oerr_d;
            drain_q          <= drain_d;
            clear_q          <= clear_d;
            rf_we_q          <= rf_we_d;
            rf_waddr_q       <= rf_waddr_d;
            rf_wdata_q       <= rf_wdata_d;
            bp_update_q      <= bp_update_d;
            bp_pc_q          <= bp_pc_d;
            bp_taken_q       <= bp_taken_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            exc_valid_q      <= exc_valid_d;
            exc_cause_q      <= exc_cause_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_inc),
        .clr   (1'b0),
        .cnt   (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mp_inc),
        .clr   (1'b0),
        .cnt   (mispredict_cnt)
    );

    assign clear          = clear_q;
    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign bp_update      = bp_update_q;
    assign bp_pc          = bp_pc_q;
    assign bp_taken       = bp_taken_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign exc_valid      = exc_valid_q;
    assign exc_cause      = exc_cause_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_branch_commiter.sv
// Directed bench for branch_commiter: vector table for single commits, hand sequences for redirect/fault/reset/saturation.
module tb_branch_commiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_res = '0, alu_pc = '0;
    logic [4:0]  alu_rd = '0;
    logic        alu_valid = 1'b0, alu_o_error = 1'b0, alu_i_error = 1'b0;
    logic        alu_req = 1'b0, alu_mispredict = 1'b0, alu_is_branch = 1'b0;
    logic        redirect_ack = 1'b0, exc_ack = 1'b0;

    logic        clear, rf_we, bp_update, bp_taken, flush, redirect_valid, exc_valid, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, bp_pc, redirect_pc, branch_cnt, mispredict_cnt;
    logic [1:0]  exc_cause;

    logic        s_clear, s_rf_we, s_bp_update, s_bp_taken, s_flush, s_redirect_valid, s_exc_valid, s_busy;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata, s_bp_pc, s_redirect_pc;
    logic [1:0]  s_exc_cause, s_branch_cnt, s_mispredict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_commiter dut (
        .clk(clk), .rst_n(rst_n), .alu_res(alu_res), .alu_rd(alu_rd), .alu_valid(alu_valid),
        .alu_o_error(alu_o_error), .alu_i_error(alu_i_error), .alu_req(alu_req),
        .alu_mispredict(alu_mispredict), .alu_is_branch(alu_is_branch), .alu_pc(alu_pc),
        .clear(clear), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_ack(exc_ack), .busy(busy),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    branch_commiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .alu_res(alu_res), .alu_rd(alu_rd), .alu_valid(alu_valid),
        .alu_o_error(alu_o_error), .alu_i_error(alu_i_error), .alu_req(alu_req),
        .alu_mispredict(alu_mispredict), .alu_is_branch(alu_is_branch), .alu_pc(alu_pc),
        .clear(s_clear), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .bp_update(s_bp_update), .bp_pc(s_bp_pc), .bp_taken(s_bp_taken), .flush(s_flush),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .redirect_ack(redirect_ack),
        .exc_valid(s_exc_valid), .exc_cause(s_exc_cause), .exc_ack(exc_ack), .busy(s_busy),
        .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        req;
        logic        isbr;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_bp;
        logic [31:0] exp_bp_pc;
        logic        exp_taken;
        logic [31:0] exp_bcnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [4:0] rd, input logic [31:0] pc,
                         input logic req, input logic misp, input logic isbr,
                         input logic ierr, input logic oerr);
        alu_valid      = 1'b1;
        alu_res        = res;
        alu_rd         = rd;
        alu_pc         = pc;
        alu_req        = req;
        alu_mispredict = misp;
        alu_is_branch  = isbr;
        alu_i_error    = ierr;
        alu_o_error    = oerr;
    endtask

    task automatic misp_seq(input logic [31:0] pc, input logic [31:0] res, input logic req,
                            input logic [31:0] exp_pc, input logic [31:0] exp_b, input logic [31:0] exp_m);
        drive(res, 5'd1, pc, req, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("ms_clear", 32'(clear), 32'd1);
        alu_valid = 1'b0;
        step();
        chk("ms_flush", 32'(flush), 32'd1);
        chk("ms_rv", 32'(redirect_valid), 32'd1);
        chk("ms_rpc", redirect_pc, exp_pc);
        chk("ms_bcnt", branch_cnt, exp_b);
        chk("ms_mcnt", mispredict_cnt, exp_m);
        redirect_ack = 1'b1;
        step();
        redirect_ack = 1'b0;
        chk("ms_rv_drop", 32'(redirect_valid), 32'd0);
        chk("ms_flush_pulse", 32'(flush), 32'd0);
        chk("ms_drain_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("ms_drain_last", 32'(busy), 32'd1);
        step();
        chk("ms_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'd1, 5'd5, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd1, 1'b0, 32'h0, 1'b0, 32'd0};
        vecs[1] = '{32'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 32'd0};
        vecs[2] = '{32'd1, 5'd31, 32'h0, 1'b0, 1'b0, 1'b1, 5'd31, 32'd1, 1'b0, 32'h0, 1'b0, 32'd0};
        vecs[3] = '{32'h140, 5'd0, 32'h100, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h100, 1'b1, 32'd1};
        vecs[4] = '{32'h380, 5'd0, 32'h300, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h300, 1'b0, 32'd2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_clear", 32'(clear), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_exc", 32'(exc_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcnt", branch_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].res, vecs[i].rd, vecs[i].pc, vecs[i].req, 1'b0, vecs[i].isbr, 1'b0, 1'b0);
            step();
            chk("v_clear", 32'(clear), 32'd1);
            chk("v_busy_commit", 32'(busy), 32'd1);
            alu_valid = 1'b0;
            step();
            chk("v_clear_pulse", 32'(clear), 32'd0);
            chk("v_rf_we", 32'(rf_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk("v_waddr", 32'(rf_waddr), 32'(vecs[i].exp_waddr));
                chk("v_wdata", rf_wdata, vecs[i].exp_wdata);
            end
            chk("v_bp_update", 32'(bp_update), 32'(vecs[i].exp_bp));
            if (vecs[i].exp_bp) begin
                chk("v_bp_pc", bp_pc, vecs[i].exp_bp_pc);
                chk("v_bp_taken", 32'(bp_taken), 32'(vecs[i].exp_taken));
            end
            chk("v_flush", 32'(flush), 32'd0);
            chk("v_busy_idle", 32'(busy), 32'd0);
            chk("v_bcnt", branch_cnt, vecs[i].exp_bcnt);
            chk("v_mcnt", mispredict_cnt, 32'd0);
        end

        // Not-taken mispredict with a wrong-path result injected during drain.
        drive(32'h0, 5'd2, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("m0_clear", 32'(clear), 32'd1);
        alu_valid = 1'b0;
        step();
        chk("m0_flush", 32'(flush), 32'd1);
        chk("m0_bp_update", 32'(bp_update), 32'd1);
        chk("m0_bp_taken", 32'(bp_taken), 32'd0);
        chk("m0_rpc", redirect_pc, 32'h204);
        chk("m0_mcnt", mispredict_cnt, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("m0_rv_hold", 32'(redirect_valid), 32'd1);
            chk("m0_rpc_hold", redirect_pc, 32'h204);
            chk("m0_flush_once", 32'(flush), 32'd0);
        end
        redirect_ack = 1'b1;
        step();
        redirect_ack = 1'b0;
        chk("m0_rv_drop", 32'(redirect_valid), 32'd0);
        chk("m0_drain", 32'(busy), 32'd1);
        drive(32'd9, 5'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("m0_wp_clear", 32'(clear), 32'd1);
        alu_valid = 1'b0;
        step();
        chk("m0_wp_rf_we", 32'(rf_we), 32'd0);
        chk("m0_wp_bp", 32'(bp_update), 32'd0);
        chk("m0_wp_clear_once", 32'(clear), 32'd0);
        chk("m0_drain_end", 32'(busy), 32'd1);
        step();
        chk("m0_idle", 32'(busy), 32'd0);
        chk("m0_rf_we_none", 32'(rf_we), 32'd0);
        chk("m0_bcnt", branch_cnt, 32'd3);
        chk("m0_mcnt_end", mispredict_cnt, 32'd1);

        misp_seq(32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0000_0000, 32'd4, 32'd2);
        misp_seq(32'h500, 32'h1000, 1'b1, 32'h1000, 32'd5, 32'd3);

        // Both error flags: illegal wins; fault ignores alu_valid.
        drive(32'h44, 5'd3, 32'h700, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("e_clear", 32'(clear), 32'd1);
        alu_valid = 1'b0;
        step();
        chk("e_valid", 32'(exc_valid), 32'd1);
        chk("e_cause", 32'(exc_cause), 32'd1);
        chk("e_rf_we", 32'(rf_we), 32'd0);
        chk("e_bp", 32'(bp_update), 32'd0);
        chk("e_flush", 32'(flush), 32'd0);
        chk("e_rv", 32'(redirect_valid), 32'd0);
        drive(32'd1, 5'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("e_no_clear", 32'(clear), 32'd0);
            chk("e_hold", 32'(exc_valid), 32'd1);
            chk("e_cause_hold", 32'(exc_cause), 32'd1);
        end
        exc_ack   = 1'b1;
        alu_valid = 1'b0;
        step();
        exc_ack = 1'b0;
        chk("e_ack_valid", 32'(exc_valid), 32'd0);
        chk("e_ack_cause", 32'(exc_cause), 32'd0);
        chk("e_idle", 32'(busy), 32'd0);
        chk("e_bcnt", branch_cnt, 32'd5);
        chk("e_mcnt", mispredict_cnt, 32'd3);

        drive(32'h0, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        alu_valid = 1'b0;
        step();
        chk("o_cause", 32'(exc_cause), 32'd2);
        chk("o_rf_we", 32'(rf_we), 32'd0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        chk("o_ack", 32'(exc_valid), 32'd0);

        // Asynchronous reset while a redirect is pending.
        drive(32'h0, 5'd1, 32'h600, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        alu_valid = 1'b0;
        step();
        chk("r_rv_before", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r_rv", 32'(redirect_valid), 32'd0);
        chk("r_rpc", redirect_pc, 32'd0);
        chk("r_flush", 32'(flush), 32'd0);
        chk("r_bp", 32'(bp_update), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_bcnt", branch_cnt, 32'd0);
        chk("r_mcnt", mispredict_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("r_idle", 32'(busy), 32'd0);
        chk("r_rv_after", 32'(redirect_valid), 32'd0);

        // Saturation: 2-bit counters stop at 3 while the 32-bit one keeps counting.
        for (int k = 0; k < 4; k++) begin
            drive(32'h0, 5'd0, 32'h800, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
            alu_valid = 1'b0;
            step();
            chk("s_bcnt_wide", branch_cnt, 32'(k + 1));
            chk("s_bcnt_sat", 32'(s_branch_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
        end
        chk("s_mcnt_sat", 32'(s_mispredict_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1, "timeout");
    end
endmodule
